// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared types and constants for the parametrised UART transmitter
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    // Literals carry an ST_ prefix so they cannot collide with the PARITY parameter.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // 100 MHz system clock / ~1.8 Mbaud
    localparam int DEFAULT_CLKS_PER_BAUD = 55;

    function automatic logic parity_of(input logic [8:0] word, input parity_t mode);
        return (mode == PAR_ODD) ? ~(^word) : (^word);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_param_if.sv
// ============================================================================
// uart_tx_param_if : valid/ready word handshake into the UART transmitter
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// uart_tx_fifo : synchronous FIFO with occupancy count, async active-low reset
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                   clock,
    input  wire logic                   reset_n,
    input  wire logic                   push,
    input  wire logic [WIDTH-1:0]       push_data,
    input  wire logic                   pop,
    output logic      [WIDTH-1:0]       pop_data,
    output logic                        full,
    output logic                        empty,
    output logic      [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through the count.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_param.sv
// ============================================================================
// uart_tx_param : parametrised UART transmitter (width/parity/stop) with FIFO
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_param
    import uart_pkg::*;
#(
    parameter int      CLKS_PER_BAUD = DEFAULT_CLKS_PER_BAUD,
    parameter int      DATA_BITS     = 8,
    parameter parity_t PARITY        = PAR_NONE,
    parameter int      STOP_BITS     = 1,
    parameter int      FIFO_DEPTH    = 4
) (
    input  wire logic                        clock,
    input  wire logic                        reset_n,
    uart_tx_param_if.slave                   bus,
    output logic                             uart_tx,
    output logic                             tx_busy,
    output logic                             tx_done,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BAUD);
    localparam int                IDX_W     = 4;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BAUD - 1);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

    if (CLKS_PER_BAUD < 2) begin : g_bad_baud
        $error("uart_tx_param: CLKS_PER_BAUD must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_head;

    tx_state_t            state,    state_next;
    logic [BAUD_W-1:0]    baud_cnt, baud_next;
    logic [IDX_W-1:0]     bit_idx,  idx_next;
    logic [DATA_BITS-1:0] shift,    shift_next;
    logic                 par_bit,  par_next;
    logic                 line_next;
    logic                 busy_next;
    logic                 done_next;
    logic                 start_frame;
    logic                 baud_end;

    assign bus.tx_ready = !fifo_full;
    assign baud_end     = (baud_cnt == BAUD_LAST);
    assign fifo_pop     = start_frame;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (bus.tx_valid),
        .push_data (bus.tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            uart_tx  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= idx_next;
            shift    <= shift_next;
            par_bit  <= par_next;
            uart_tx  <= line_next;
            tx_busy  <= busy_next;
            tx_done  <= done_next;
        end
    end

    always_comb begin
        state_next  = state;
        baud_next   = '0;
        idx_next    = bit_idx;
        shift_next  = shift;
        par_next    = par_bit;
        line_next   = uart_tx;
        busy_next   = tx_busy;
        done_next   = 1'b0;
        start_frame = 1'b0;

        if (state != ST_IDLE) begin
            baud_next = baud_end ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                start_frame = !fifo_empty;
            end
            ST_START: begin
                if (baud_end) begin
                    state_next = ST_DATA;
                    idx_next   = '0;
                    line_next  = shift[0];
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    shift_next = shift >> 1;
                    if (bit_idx == DATA_LAST) begin
                        idx_next = '0;
                        if (PARITY == PAR_NONE) begin
                            state_next = ST_STOP;
                            line_next  = 1'b1;
                        end else begin
                            state_next = ST_PARITY;
                            line_next  = par_bit;
                        end
                    end else begin
                        idx_next  = bit_idx + 1'b1;
                        line_next = shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (baud_end) begin
                    state_next = ST_STOP;
                    idx_next   = '0;
                    line_next  = 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    if (bit_idx == STOP_LAST) begin
                        done_next   = 1'b1;
                        start_frame = !fifo_empty;
                        if (fifo_empty) begin
                            state_next = ST_IDLE;
                            busy_next  = 1'b0;
                            line_next  = 1'b1;
                        end
                    end else begin
                        idx_next = bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                line_next  = 1'b1;
                busy_next  = 1'b0;
            end
        endcase

        // A new frame starts on this edge, whether from idle or straight after a stop bit.
        if (start_frame) begin
            state_next = ST_START;
            baud_next  = '0;
            idx_next   = '0;
            shift_next = fifo_head;
            par_next   = parity_of(9'(fifo_head), PARITY);
            line_next  = 1'b0;
            busy_next  = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_param.sv
// ============================================================================
// tb_uart_tx_param : five transmitter configurations driven with random traffic
// and compared cycle by cycle against a frame-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_param;
    import uart_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int NL    = 5;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          go = 0;
    int          burst_n = 0;
    bit          use_lane = 1'b1;
    bit          rand_mode = 1'b0;
    logic [8:0]  dword = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Lane configurations: 8N1, 8E1, 8O1, 8O2, 7N1
    function automatic int cfg_db(input int i);
        return (i == 4) ? 7 : 8;
    endfunction
    function automatic parity_t cfg_par(input int i);
        case (i)
            1:       return PAR_EVEN;
            2, 3:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction
    function automatic int cfg_sb(input int i);
        return (i == 3) ? 2 : 1;
    endfunction
    function automatic logic [8:0] cfg_word(input int i);
        case (i)
            3:       return 9'h001;
            4:       return 9'h07F;
            default: return 9'h0A5;
        endcase
    endfunction

    // Line level of bit slot idx in a frame: start, data LSB first, parity, stops.
    function automatic logic exp_line(input logic [8:0] w, input int idx, input int db, input parity_t p);
        int ones;
        if (idx == 0) return 1'b0;
        if (idx <= db) return w[idx-1];
        if (p != PAR_NONE && idx == db + 1) begin
            ones = 0;
            for (int k = 0; k < db; k++) ones += int'(w[k]);
            return (p == PAR_ODD) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        end
        return 1'b1;
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int      DB   = cfg_db(g);
        localparam parity_t PAR  = cfg_par(g);
        localparam int      SB   = cfg_sb(g);
        localparam int      FLEN = (1 + DB + ((PAR != PAR_NONE) ? 1 : 0) + SB) * CPB;

        uart_tx_param_if #(.DATA_BITS(DB)) bus ();
        logic                       dut_tx;
        logic                       dut_busy;
        logic                       dut_done;
        logic [$clog2(DEPTH):0]     dut_cnt;

        uart_tx_param #(
            .CLKS_PER_BAUD (CPB),
            .DATA_BITS     (DB),
            .PARITY        (PAR),
            .STOP_BITS     (SB),
            .FIFO_DEPTH    (DEPTH)
        ) dut (
            .clock      (clock),
            .reset_n    (reset_n),
            .bus        (bus),
            .uart_tx    (dut_tx),
            .tx_busy    (dut_busy),
            .tx_done    (dut_done),
            .fifo_count (dut_cnt)
        );

        // Driver: bursts of held-valid words, random traffic, or idle with tx_data churning.
        int rem  = 0;
        int seen = 0;
        bit first = 1'b0;
        bit rdy = 1'b0;
        initial begin
            bus.tx_valid = 1'b0;
            bus.tx_data  = '0;
            forever begin
                @(negedge clock);
                if (bus.tx_valid && rdy && reset_n && rem > 0) begin
                    rem--;
                    first = 1'b0;
                end
                if (go != seen) begin
                    seen  = go;
                    rem   = burst_n;
                    first = 1'b1;
                end
                if (rem > 0) begin
                    bus.tx_valid = 1'b1;
                    bus.tx_data  = first ? DB'(use_lane ? cfg_word(g) : dword) : DB'($urandom);
                end else if (rand_mode) begin
                    bus.tx_valid = ($urandom_range(0, 2) != 0);
                    bus.tx_data  = DB'($urandom);
                end else begin
                    bus.tx_valid = 1'b0;
                    bus.tx_data  = DB'($urandom);
                end
                rdy = bus.tx_ready;
            end
        end

        // Reference model: a queue of accepted words and the offset into the current frame.
        logic [8:0] mq[$];
        logic [8:0] cur = '0;
        bit         act = 1'b0;
        int         off = 0;
        bit         done_e = 1'b0;

        initial begin
            forever begin
                @(posedge clock);
                done_e = 1'b0;
                if (!reset_n) begin
                    mq.delete();
                    act = 1'b0;
                    off = 0;
                end else begin
                    bit         acc;
                    logic [8:0] din;
                    acc = bus.tx_valid && (mq.size() < DEPTH);
                    din = 9'(bus.tx_data);
                    if (act) begin
                        off++;
                        if (off == FLEN) begin
                            done_e = 1'b1;
                            act    = 1'b0;
                        end
                    end
                    if (!act && mq.size() > 0) begin
                        cur = mq.pop_front();
                        act = 1'b1;
                        off = 0;
                    end
                    if (acc) mq.push_back(din);
                end
                #1;
                check($sformatf("L%0d uart_tx", g), 32'(dut_tx),
                      32'(act ? exp_line(cur, off / CPB, DB, PAR) : 1'b1));
                check($sformatf("L%0d tx_busy", g), 32'(dut_busy), 32'(act));
                check($sformatf("L%0d tx_done", g), 32'(dut_done), 32'(done_e));
                check($sformatf("L%0d fifo_count", g), 32'(dut_cnt), 32'(mq.size()));
                check($sformatf("L%0d tx_ready", g), 32'(bus.tx_ready), 32'(mq.size() < DEPTH));
            end
        end

        // Asynchronous reset must clear the line and FIFO before the next clock edge.
        initial begin
            @(posedge reset_n);
            forever begin
                @(negedge reset_n);
                #1;
                check($sformatf("L%0d async uart_tx", g), 32'(dut_tx), 32'd1);
                check($sformatf("L%0d async tx_busy", g), 32'(dut_busy), 32'd0);
                check($sformatf("L%0d async tx_done", g), 32'(dut_done), 32'd0);
                check($sformatf("L%0d async fifo_count", g), 32'(dut_cnt), 32'd0);
                check($sformatf("L%0d async tx_ready", g), 32'(bus.tx_ready), 32'd1);
                mq.delete();
                act    = 1'b0;
                off    = 0;
                done_e = 1'b0;
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;

        // One directed word per lane, then idle while tx_data keeps changing.
        @(posedge clock); #2;
        use_lane = 1'b1; burst_n = 1; go++;
        repeat (70) @(posedge clock); #2;

        // Six words with valid held high: fills the FIFO, frames run back-to-back.
        use_lane = 1'b0; dword = 9'(($urandom)); burst_n = 6; go++;
        repeat (330) @(posedge clock); #2;

        rand_mode = 1'b1;
        repeat (400) @(posedge clock); #2;
        rand_mode = 1'b0;
        repeat (300) @(posedge clock); #2;

        // 0x3C plus two queued words, then reset while the data bits are on the line.
        dword = 9'h03C; burst_n = 3; go++;
        repeat (10) @(posedge clock);
        #3 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #4 reset_n = 1'b1;

        @(posedge clock); #2;
        dword = 9'h055; burst_n = 1; go++;
        repeat (70) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
